// File: rtl/rt_ctrl_pkg.sv
// Shared types for the racetrack line controller: command ops, track ids, FSM states.
// Also provides the op-to-state mapping used when a shift sequence completes.
package rt_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_LIM   = 2'd2,
      OP_HOME  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      TRK_DATA    = 2'd0,
      TRK_MASK    = 2'd1,
      TRK_PROGRAM = 2'd2,
      TRK_LIM     = 2'd3
   } track_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_ON,
      ST_SHIFT_OFF,
      ST_RD,
      ST_WR1,
      ST_WR0,
      ST_BZ,
      ST_RESP
   } state_e;

   function automatic state_e op_state(input op_e op);
      case (op)
         OP_READ:  return ST_RD;
         OP_WRITE: return ST_WR1;
         OP_LIM:   return ST_BZ;
         default:  return ST_RESP;
      endcase
   endfunction

endpackage

// File: rtl/rt_pulse_gen.sv
// Down-counter timer: load N, busy while count>0, done on the last counted cycle.
// Reused for shift-high, shift-gap and Bz pulse durations.
module rt_pulse_gen #(
   parameter int CW = 8
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          load_i,
   input  logic [CW-1:0] len_i,
   output logic          busy_o,
   output logic          done_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         cnt_q <= '0;
      else if (load_i)
         cnt_q <= len_i;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CW'(1);
   end

   assign busy_o = (cnt_q != '0);
   assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/rt_line_ctrl.sv
// Racetrack line sequencer: shifts the selected track to the target offset, then pulses the line.
// Define RT_SHIFT_STATS_EN to build the saturating shift-pulse counter on shift_cnt_o.
module rt_line_ctrl
   import rt_ctrl_pkg::*;
#(
   parameter int NB        = 32,
   parameter int NP        = 8,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1,
   parameter int BZ_CYC    = 2,
   localparam int OFFW     = $clog2(NB / NP)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [1:0]        cmd_track_i,
   input  logic [OFFW-1:0]   cmd_offset_i,
   input  logic [NP-1:0]     cmd_wdata_i,
   input  logic              cmd_bz_dir_i,
   output logic              rsp_valid_o,
   output logic [NP-1:0]     rsp_rdata_o,
   output logic              rsp_err_o,
   output logic [3:0]        current_s_o,
   output logic [3:0]        current_m_o,
   output logic              read_current_o,
   output logic [2:0]        write_i_o,
   output logic [3*NP-1:0]   write_en_o,
   output logic              bz_s_o,
   output logic              bz_m_o,
   input  logic [NP-1:0]     r_port_data_i,
   input  logic [NP-1:0]     r_port_mask_i,
   input  logic [NP-1:0]     r_port_program_i,
   input  logic [NP-1:0]     r_port_lim_i,
   output logic [31:0]       shift_cnt_o
);

   localparam logic [7:0] LEN_P = 8'(PULSE_CYC);
   localparam logic [7:0] LEN_G = 8'(GAP_CYC);
   localparam logic [7:0] LEN_B = 8'(BZ_CYC);

   state_e            state_q, state_d;
   logic              ready_q, accept, err_in;
   op_e               op_in, op_q, op_d;
   track_e            trk_in, trk_q, trk_d;
   logic [OFFW-1:0]   tgt_in, tgt_q, tgt_d;
   logic [OFFW-1:0]   pos_q [4];
   logic [NP-1:0]     wdata_q, wdata_d, rport_sel;
   logic              bzdir_q, bzdir_d, dir_q, dir_d, err_q, err_d;
   logic              pg_load, pg_busy, pg_done, tmr_exp;
   logic [7:0]        pg_len;

   logic              rsp_valid_q, rsp_err_q, rd_cur_q, bz_s_q, bz_m_q;
   logic [NP-1:0]     rsp_rdata_q;
   logic [3:0]        cur_s_q, cur_m_q;
   logic [2:0]        wr_i_q;
   logic [3*NP-1:0]   wen_q;

   assign op_in  = op_e'(cmd_op_i);
   assign trk_in = track_e'(cmd_track_i);
   assign tgt_in = (op_in == OP_HOME) ? '0 : cmd_offset_i;
   assign err_in = ((op_in == OP_WRITE) && (trk_in == TRK_LIM)) ||
                   ((op_in == OP_LIM) && (trk_in != TRK_LIM));
   assign accept = cmd_valid_i && ready_q;

   // Fields as they will be after this edge, so outputs can be registered on state entry.
   always_comb begin
      op_d    = op_q;
      trk_d   = trk_q;
      tgt_d   = tgt_q;
      wdata_d = wdata_q;
      bzdir_d = bzdir_q;
      err_d   = err_q;
      dir_d   = dir_q;
      if (accept) begin
         op_d    = op_in;
         trk_d   = trk_in;
         tgt_d   = tgt_in;
         wdata_d = cmd_wdata_i;
         bzdir_d = cmd_bz_dir_i;
         err_d   = err_in;
         dir_d   = !err_in && (tgt_in > pos_q[trk_in]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q    <= op_in;
         trk_q   <= trk_in;
         tgt_q   <= tgt_in;
         wdata_q <= cmd_wdata_i;
         bzdir_q <= cmd_bz_dir_i;
         err_q   <= err_d;
         dir_q   <= dir_d;
      end
   end

   assign tmr_exp = pg_done || !pg_busy;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (accept) begin
               if (err_in)                        state_d = ST_RESP;
               else if (pos_q[trk_in] == tgt_in)  state_d = op_state(op_in);
               else                               state_d = ST_SHIFT_ON;
            end
         ST_SHIFT_ON:  if (tmr_exp) state_d = ST_SHIFT_OFF;
         ST_SHIFT_OFF:
            if (tmr_exp)
               state_d = (pos_q[trk_q] != tgt_q) ? ST_SHIFT_ON : op_state(op_q);
         ST_RD:   state_d = ST_RESP;
         ST_WR1:  state_d = ST_WR0;
         ST_WR0:  state_d = ST_RESP;
         ST_BZ:   if (tmr_exp) state_d = ST_RD;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pg_len = LEN_B;
      if (state_d == ST_SHIFT_ON)       pg_len = LEN_P;
      else if (state_d == ST_SHIFT_OFF) pg_len = LEN_G;
   end

   assign pg_load = (state_d != state_q) &&
                    (state_d inside {ST_SHIFT_ON, ST_SHIFT_OFF, ST_BZ});

   rt_pulse_gen #(.CW(8)) u_pulse (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .load_i (pg_load),
      .len_i  (pg_len),
      .busy_o (pg_busy),
      .done_o (pg_done)
   );

   always_comb begin
      case (trk_d)
         TRK_DATA:    rport_sel = r_port_data_i;
         TRK_MASK:    rport_sel = r_port_mask_i;
         TRK_PROGRAM: rport_sel = r_port_program_i;
         default:     rport_sel = r_port_lim_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         for (int t = 0; t < 4; t++) pos_q[t] <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         cur_s_q     <= '0;
         cur_m_q     <= '0;
         rd_cur_q    <= 1'b0;
         wr_i_q      <= '0;
         wen_q       <= '0;
         bz_s_q      <= 1'b0;
         bz_m_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         if ((state_q == ST_SHIFT_ON) && (state_d == ST_SHIFT_OFF))
            pos_q[trk_q] <= dir_q ? pos_q[trk_q] + OFFW'(1) : pos_q[trk_q] - OFFW'(1);

         cur_s_q     <= '0;
         cur_m_q     <= '0;
         wr_i_q      <= '0;
         wen_q       <= '0;
         rd_cur_q    <= (state_d == ST_RD);
         bz_m_q      <= (state_d == ST_BZ);
         bz_s_q      <= (state_d == ST_BZ) && bzdir_d;
         rsp_valid_q <= (state_d == ST_RESP);
         rsp_err_q   <= (state_d == ST_RESP) && err_d;
         rsp_rdata_q <= '0;
         if (state_d != ST_IDLE) cur_s_q[trk_d] <= dir_d;
         if (state_d == ST_SHIFT_ON) cur_m_q[trk_d] <= 1'b1;
         if (trk_d != TRK_LIM) begin
            if (state_d == ST_WR1) begin
               wr_i_q[trk_d]               <= 1'b1;
               wen_q[int'(trk_d)*NP +: NP] <= wdata_d;
            end else if (state_d == ST_WR0) begin
               wen_q[int'(trk_d)*NP +: NP] <= ~wdata_d;
            end
         end
         if ((state_d == ST_RESP) && !err_d && ((op_d == OP_READ) || (op_d == OP_LIM)))
            rsp_rdata_q <= rport_sel;
      end
   end

`ifdef RT_SHIFT_STATS_EN
   logic [31:0] shift_cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         shift_cnt_q <= '0;
      else if ((state_d == ST_SHIFT_ON) && (state_q != ST_SHIFT_ON) && (shift_cnt_q != '1))
         shift_cnt_q <= shift_cnt_q + 32'd1;
   end

   assign shift_cnt_o = shift_cnt_q;
`else
   assign shift_cnt_o = '0;
`endif

   assign cmd_ready_o    = ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_err_o      = rsp_err_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign current_s_o    = cur_s_q;
   assign current_m_o    = cur_m_q;
   assign read_current_o = rd_cur_q;
   assign write_i_o      = wr_i_q;
   assign write_en_o     = wen_q;
   assign bz_s_o         = bz_s_q;
   assign bz_m_o         = bz_m_q;

endmodule

// File: tb/tb_rt_line_ctrl.sv
// Self-checking bench for rt_line_ctrl: directed vector table, mid-shift reset, randomized commands.
// Honours RT_SHIFT_STATS_EN when checking shift_cnt_o.
module tb_rt_line_ctrl;

   localparam int NB = 32, NP = 8, P = 2, G = 1, BZ = 2, OFFW = 2, PG = P + G;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd_op = '0, cmd_trk = '0;
   logic [OFFW-1:0]   cmd_off = '0;
   logic [NP-1:0]     cmd_wd = '0;
   logic              cmd_bzd = 1'b0;
   logic [NP-1:0]     rp [4];
   logic              cmd_ready_o, rsp_valid_o, rsp_err_o, read_current_o, bz_s_o, bz_m_o;
   logic [NP-1:0]     rsp_rdata_o;
   logic [3:0]        current_s_o, current_m_o;
   logic [2:0]        write_i_o;
   logic [3*NP-1:0]   write_en_o;
   logic [31:0]       shift_cnt_o;

   int checks = 0, failures = 0;
   int mpos [4];
   int total_pulses = 0;

   always #5 clk = ~clk;

   rt_line_ctrl #(.NB(NB), .NP(NP), .PULSE_CYC(P), .GAP_CYC(G), .BZ_CYC(BZ)) dut (
      .clk_i(clk), .rstn_i(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op), .cmd_track_i(cmd_trk), .cmd_offset_i(cmd_off),
      .cmd_wdata_i(cmd_wd), .cmd_bz_dir_i(cmd_bzd),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .current_s_o(current_s_o), .current_m_o(current_m_o), .read_current_o(read_current_o),
      .write_i_o(write_i_o), .write_en_o(write_en_o), .bz_s_o(bz_s_o), .bz_m_o(bz_m_o),
      .r_port_data_i(rp[0]), .r_port_mask_i(rp[1]), .r_port_program_i(rp[2]),
      .r_port_lim_i(rp[3]), .shift_cnt_o(shift_cnt_o)
   );

   typedef struct {
      logic [1:0]      op, trk;
      logic [OFFW-1:0] off;
      logic [NP-1:0]   wd;
      logic            bzd;
      int              lat, pulses;
      logic            dir, err;
      logic [NP-1:0]   rdata;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(input logic [1:0] op, trk, input int off, input logic [NP-1:0] wd,
                               input logic bzd, input int lat, pulses, input logic dir, err,
                               input logic [NP-1:0] rdata);
      vec_t v;
      v.op = op; v.trk = trk; v.off = OFFW'(off); v.wd = wd; v.bzd = bzd;
      v.lat = lat; v.pulses = pulses; v.dir = dir; v.err = err; v.rdata = rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic all_out_zero();
      return ~|{cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, current_s_o, current_m_o,
                read_current_o, write_i_o, write_en_o, bz_s_o, bz_m_o, shift_cnt_o};
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (!cmd_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_ready"}, 32'(cmd_ready_o), 32'd1);
   endtask

   // Issue one command and check every line output on every cycle until the response.
   task automatic run_cmd(input string name, input vec_t v);
      int c, t, m_bad, s_bad, w_bad, r_bad, b_bad;
      logic [3:0] oh, em, es;
      logic [3*NP-1:0] ew;
      logic [2:0] ewi;
      logic er, ebm, ebs, got;
      t = int'(v.trk);
      oh = 4'b0001 << t;
      wait_ready(name);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_trk = v.trk; cmd_off = v.off;
      cmd_wd = v.wd; cmd_bzd = v.bzd;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_trk = 2'($urandom); cmd_wd = NP'($urandom);
      c = 1; got = 1'b0; m_bad = 0; s_bad = 0; w_bad = 0; r_bad = 0; b_bad = 0;
      while (!got && c <= v.lat + 10) begin
         em = (c <= v.pulses * PG && ((c - 1) % PG) < P) ? oh : 4'b0;
         es = (v.dir && c <= v.lat) ? oh : 4'b0;
         ew = '0; ewi = '0;
         if (v.op == 2'd1 && !v.err && t < 3) begin
            if (c == v.lat - 2) begin ew[t*NP +: NP] = v.wd;  ewi[t] = 1'b1; end
            if (c == v.lat - 1) begin ew[t*NP +: NP] = ~v.wd; end
         end
         er  = (v.op == 2'd0 || v.op == 2'd2) && !v.err && (c == v.lat - 1);
         ebm = (v.op == 2'd2) && !v.err && (c >= v.lat - 1 - BZ) && (c <= v.lat - 2);
         ebs = ebm && v.bzd;
         if (current_m_o !== em) m_bad++;
         if (current_s_o !== es) s_bad++;
         if (write_en_o !== ew || write_i_o !== ewi) w_bad++;
         if (read_current_o !== er) r_bad++;
         if (bz_m_o !== ebm || bz_s_o !== ebs) b_bad++;
         if (rsp_valid_o) got = 1'b1;
         else begin
            @(negedge clk);
            c++;
         end
      end
      chk({name, "_latency"}, got ? 32'(c) : 32'hFFFF_FFFF, 32'(v.lat));
      chk({name, "_err"}, 32'(rsp_err_o), 32'(v.err));
      chk({name, "_rdata"}, 32'(rsp_rdata_o), 32'(v.rdata));
      chk({name, "_shift_pulses"}, 32'(m_bad), 32'd0);
      chk({name, "_shift_dir"}, 32'(s_bad), 32'd0);
      chk({name, "_write_pulses"}, 32'(w_bad), 32'd0);
      chk({name, "_read_pulse"}, 32'(r_bad), 32'd0);
      chk({name, "_bz_pulse"}, 32'(b_bad), 32'd0);
      @(negedge clk);
      chk({name, "_after_rsp"}, 32'({cmd_ready_o, rsp_valid_o}), 32'b10);
      if (!v.err) mpos[t] = (v.op == 2'd3) ? 0 : int'(v.off);
      total_pulses += v.pulses;
   endtask

   // Reference model: expected timing and data straight from the command rules.
   function automatic vec_t model(input logic [1:0] op, trk, input int off,
                                  input logic [NP-1:0] wd, input logic bzd);
      logic err;
      int tgt, d, base;
      err  = (op == 2'd1 && trk == 2'd3) || (op == 2'd2 && trk != 2'd3);
      tgt  = (op == 2'd3) ? 0 : off;
      d    = err ? 0 : tgt - mpos[trk];
      base = err ? 1 : (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : (op == 2'd2) ? 2 + BZ : 1;
      return mk(op, trk, off, wd, bzd, base + (d < 0 ? -d : d) * PG, d < 0 ? -d : d,
                d > 0, err, (!err && (op == 2'd0 || op == 2'd2)) ? rp[trk] : '0);
   endfunction

   initial begin
      int n;
      vec_t v;
      for (int t = 0; t < 4; t++) mpos[t] = 0;
      rp[0] = 8'hA5; rp[1] = 8'h5A; rp[2] = 8'h0F; rp[3] = 8'hC3;

      //          op trk off wd     bz lat p  dir err rdata
      tbl[0]  = mk(0, 0, 0, 8'h00, 0, 2,  0, 0, 0, 8'hA5);
      tbl[1]  = mk(1, 0, 3, 8'h3C, 0, 12, 3, 1, 0, 8'h00);
      tbl[2]  = mk(0, 0, 1, 8'h00, 0, 8,  2, 0, 0, 8'hA5);
      tbl[3]  = mk(1, 3, 2, 8'h77, 0, 1,  0, 0, 1, 8'h00);
      tbl[4]  = mk(2, 3, 2, 8'h00, 1, 10, 2, 1, 0, 8'hC3);
      tbl[5]  = mk(2, 0, 0, 8'h00, 1, 1,  0, 0, 1, 8'h00);
      tbl[6]  = mk(0, 1, 3, 8'h00, 0, 11, 3, 1, 0, 8'h5A);
      tbl[7]  = mk(3, 1, 2, 8'h00, 0, 10, 3, 0, 0, 8'h00);
      tbl[8]  = mk(3, 2, 1, 8'h00, 0, 1,  0, 0, 0, 8'h00);
      tbl[9]  = mk(1, 2, 0, 8'hFF, 0, 3,  0, 0, 0, 8'h00);
      tbl[10] = mk(2, 3, 1, 8'h00, 0, 7,  1, 0, 0, 8'hC3);
      tbl[11] = mk(0, 3, 3, 8'h00, 0, 8,  2, 1, 0, 8'hC3);

      repeat (2) @(negedge clk);
      chk("reset_outputs_zero", 32'(all_out_zero()), 32'd1);
      rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(cmd_ready_o), 32'd1);

      for (int i = 0; i < 12; i++) run_cmd($sformatf("vec%0d", i), tbl[i]);

`ifdef RT_SHIFT_STATS_EN
      chk("shift_cnt_table", shift_cnt_o, 32'(total_pulses));
`else
      chk("shift_cnt_table", shift_cnt_o, 32'd0);
`endif

      // Reset while the mask track is mid-pulse; positions must return to 0.
      wait_ready("abort");
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_trk = 2'd1; cmd_off = 2'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!current_m_o[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_in_shift_on", 32'(current_m_o[1]), 32'd1);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("abort_outputs_zero", 32'(all_out_zero()), 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      for (int t = 0; t < 4; t++) mpos[t] = 0;
      total_pulses = 0;
      @(negedge clk);
      chk("ready_after_abort", 32'(cmd_ready_o), 32'd1);
      run_cmd("home_mask_after_abort", mk(3, 1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00));

      for (int i = 0; i < 60; i++) begin
         for (int t = 0; t < 4; t++) rp[t] = NP'($urandom);
         v = model(2'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
                   NP'($urandom), 1'($urandom));
         run_cmd($sformatf("rnd%0d", i), v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef RT_SHIFT_STATS_EN
      chk("shift_cnt_final", shift_cnt_o, 32'(total_pulses));
`else
      chk("shift_cnt_final", shift_cnt_o, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
